mem_stage: RTL and testbench

Memory-access stage of the five-stage in-order pipeline, between the execute stage and the write-back stage. It accepts one instruction per cycle from execute over a valid/allowin handshake. It selects and extends load data returned by the synchronous data SRAM, and forms the 70-bit result bus consumed by write-back. It holds load data safely across back-pressure stalls and exports its destination register and result for forwarding and hazard detection in decode.

---
 rtl/mem_stage_if.sv | 31 +++
 rtl/mem_stage.sv | 124 ++++++++++++
 tb/tb_mem_stage.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Handshake and bus bundle between execute, the memory stage and write-back.
// The master side drives the incoming instruction and the write-back allowin.
interface mem_stage_if #(
  parameter int ES_TO_MS_BUS_WD = 74,
  parameter int MS_TO_WS_BUS_WD = 70
);
  logic                       es_to_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
  logic                       ms_allowin;
  logic                       ws_allowin;
  logic                       ms_to_ws_valid;
  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;

  modport master (
    output es_to_ms_valid,
    output es_to_ms_bus,
    output ws_allowin,
    input  ms_allowin,
    input  ms_to_ws_valid,
    input  ms_to_ws_bus
  );

  modport slave (
    input  es_to_ms_valid,
    input  es_to_ms_bus,
    input  ws_allowin,
    output ms_allowin,
    output ms_to_ws_valid,
    output ms_to_ws_bus
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: load data select/extend, stall-safe read-data hold,
// result bus to write-back and forwarding outputs for decode.
module mem_stage (
  input  logic              clk,
  input  logic              reset,
  mem_stage_if.slave        pipe,
  input  logic [31:0]       data_sram_rdata,
  output logic [4:0]        ms_real_dest,
  output logic [31:0]       mem_forward_data
);

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LB  = 3'b001;
  localparam logic [2:0] OP_LBU = 3'b010;
  localparam logic [2:0] OP_LH  = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;

  // Sub-word select plus sign/zero extension; reserved opcodes fall back to a full word.
  function automatic logic [31:0] load_extract(
    input logic [2:0]  op,
    input logic [1:0]  addr_lo,
    input logic [31:0] rd
  );
    logic        [7:0]  byte_u;
    logic signed [7:0]  byte_s;
    logic        [15:0] half_u;
    logic signed [15:0] half_s;
    logic        [31:0] res;
    byte_u = rd[{addr_lo, 3'b000} +: 8];
    half_u = addr_lo[1] ? rd[31:16] : rd[15:0];
    byte_s = $signed(byte_u);
    half_s = $signed(half_u);
    case (op)
      OP_LB:   res = 32'($signed(byte_s));
      OP_LBU:  res = {24'd0, byte_u};
      OP_LH:   res = 32'($signed(half_s));
      OP_LHU:  res = {16'd0, half_u};
      OP_LW:   res = rd;
      default: res = rd;
    endcase
    return res;
  endfunction

  logic                       ms_valid;
  logic                       ms_ready_go;
  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
  logic [31:0]                rdata_buf;
  logic                       rdata_held;

  logic                       accept;
  logic                       capture;

  logic [2:0]                 load_op;
  logic                       res_from_mem;
  logic                       gr_we;
  logic [4:0]                 dest;
  logic [31:0]                alu_result;
  logic [31:0]                pc;
  logic [31:0]                eff_rdata;
  logic [31:0]                load_data;
  logic [31:0]                final_result;

  assign ms_ready_go       = 1'b1;
  assign pipe.ms_allowin   = !ms_valid || (ms_ready_go && pipe.ws_allowin);
  assign pipe.ms_to_ws_valid = ms_valid && ms_ready_go;

  assign accept  = pipe.es_to_ms_valid && pipe.ms_allowin;
  // The SRAM only presents the load data in the first stage cycle, so a stall must
  // latch it before write-back is ready to take the instruction.
  assign capture = ms_valid && !rdata_held && !pipe.ws_allowin;

  // ---- stage register: control ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid   <= 1'b0;
      rdata_held <= 1'b0;
    end else begin
      if (pipe.ms_allowin) begin
        ms_valid <= pipe.es_to_ms_valid;
      end
      if (accept) begin
        rdata_held <= 1'b0;
      end else if (capture) begin
        rdata_held <= 1'b1;
      end
    end
  end

  // ---- stage register: instruction and held read data ----
  always_ff @(posedge clk) begin
    if (reset) begin
      es_to_ms_bus_r <= '0;
      rdata_buf      <= '0;
    end else begin
      if (accept) begin
        es_to_ms_bus_r <= pipe.es_to_ms_bus;
      end
      if (capture) begin
        rdata_buf <= data_sram_rdata;
      end
    end
  end

  // ---- combinational result formation ----
  assign load_op      = es_to_ms_bus_r[73:71];
  assign res_from_mem = es_to_ms_bus_r[70];
  assign gr_we        = es_to_ms_bus_r[69];
  assign dest         = es_to_ms_bus_r[68:64];
  assign alu_result   = es_to_ms_bus_r[63:32];
  assign pc           = es_to_ms_bus_r[31:0];

  assign eff_rdata    = rdata_held ? rdata_buf : data_sram_rdata;
  assign load_data    = load_extract(load_op, alu_result[1:0], eff_rdata);
  assign final_result = res_from_mem ? load_data : alu_result;

  // gr_we leaves ungated; write-back qualifies it with its own valid.
  assign pipe.ms_to_ws_bus = MS_TO_WS_BUS_WD'({gr_we, dest, final_result, pc});
  assign ms_real_dest      = (ms_valid && gr_we) ? dest : 5'd0;
  assign mem_forward_data  = final_result;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed literal cases plus randomized traffic
// checked every cycle against a behavioural model of the stage.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] data_sram_rdata;
  logic [4:0]  ms_real_dest;
  logic [31:0] mem_forward_data;

  int checks = 0;
  int errors = 0;

  mem_stage_if #(.ES_TO_MS_BUS_WD(74), .MS_TO_WS_BUS_WD(70)) ifc ();

  mem_stage dut (
    .clk              (clk),
    .reset            (reset),
    .pipe             (ifc),
    .data_sram_rdata  (data_sram_rdata),
    .ms_real_dest     (ms_real_dest),
    .mem_forward_data (mem_forward_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [73:0] act, input logic [73:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [73:0] mk(input int op, input bit rfm, input bit we,
                                     input int dst, input logic [31:0] addr,
                                     input logic [31:0] pc);
    return {3'(op), rfm, we, 5'(dst), addr, pc};
  endfunction

  // Reference load semantics from plain arithmetic on the word.
  function automatic logic [31:0] ref_load(input int op, input int off, input logic [31:0] rd);
    int unsigned u;
    int b;
    int h;
    u = rd;
    b = int'((u >> (8 * off)) & 32'hFF);
    h = int'((u >> (16 * (off / 2))) & 32'hFFFF);
    case (op)
      1: return (b >= 128) ? 32'(b - 256) : 32'(b);
      2: return 32'(b);
      3: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      4: return 32'(h);
      default: return rd;
    endcase
  endfunction

  // Model: what the stage holds, and the read data the load saw in its first cycle.
  logic        m_valid = 1'b0;
  logic [73:0] m_bus = '0;
  logic        m_acc = 1'b0;
  logic        started = 1'b0;
  logic [31:0] m_rd = '0;

  always @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_bus   <= '0;
      m_acc   <= 1'b0;
      started <= 1'b1;
    end else begin
      m_acc <= 1'b0;
      if (!m_valid || ifc.ws_allowin) begin
        m_valid <= ifc.es_to_ms_valid;
        if (ifc.es_to_ms_valid) begin
          m_bus <= ifc.es_to_ms_bus;
          m_acc <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [31:0] rd_use;
    logic [31:0] fin;
    logic [4:0]  dst;
    rd_use = m_acc ? data_sram_rdata : m_rd;
    m_rd <= rd_use;
    if (started) begin
      dst = m_bus[68:64];
      fin = m_bus[70] ? ref_load(int'(m_bus[73:71]), int'(m_bus[33:32]), rd_use)
                      : m_bus[63:32];
      check("model_allowin", 74'(ifc.ms_allowin), 74'(!m_valid || ifc.ws_allowin));
      check("model_valid", 74'(ifc.ms_to_ws_valid), 74'(m_valid));
      check("model_real_dest", 74'(ms_real_dest), 74'((m_valid && m_bus[69]) ? dst : 5'd0));
      if (m_valid) begin
        check("model_bus", 74'(ifc.ms_to_ws_bus), 74'({m_bus[69], dst, fin, m_bus[31:0]}));
        check("model_fwd", 74'(mem_forward_data), 74'(fin));
      end
    end
  end

  task automatic cyc(input bit v, input logic [73:0] b, input bit wsa, input logic [31:0] rd);
    @(posedge clk);
    #1;
    ifc.es_to_ms_valid = v;
    ifc.es_to_ms_bus   = b;
    ifc.ws_allowin     = wsa;
    data_sram_rdata    = rd;
  endtask

  int          ops  [7] = '{1, 1, 1, 1, 2, 3, 4};
  int          offs [7] = '{0, 1, 2, 3, 3, 2, 0};
  logic [31:0] exps [7] = '{32'h0000_0001, 32'h0000_007F, 32'hFFFF_FFFF, 32'hFFFF_FF80,
                            32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};

  initial begin
    reset              = 1'b1;
    ifc.es_to_ms_valid = 1'b0;
    ifc.es_to_ms_bus   = '0;
    ifc.ws_allowin     = 1'b1;
    data_sram_rdata    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_allowin", 74'(ifc.ms_allowin), 74'(1));
    check("reset_valid", 74'(ifc.ms_to_ws_valid), 74'(0));
    check("reset_real_dest", 74'(ms_real_dest), 74'(0));
    check("reset_bus", 74'(ifc.ms_to_ws_bus), 74'(0));
    check("reset_fwd", 74'(mem_forward_data), 74'(0));
    @(posedge clk);
    #1 reset = 1'b0;

    // Plain LW
    cyc(1, mk(0, 1, 1, 5, 32'h1000_0004, 32'h0000_0100), 1, 32'h0);
    cyc(0, '0, 1, 32'h8765_4321);
    @(negedge clk);
    check("lw_valid", 74'(ifc.ms_to_ws_valid), 74'(1));
    check("lw_result", 74'(ifc.ms_to_ws_bus[63:32]), 74'(32'h8765_4321));
    check("lw_real_dest", 74'(ms_real_dest), 74'(5));

    // Sub-word loads, back to back
    cyc(1, mk(ops[0], 1, 1, 6, 32'h1000_0000 + 32'(offs[0]), 32'h200), 1, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      if (i < 7)
        cyc(1, mk(ops[i], 1, 1, 6, 32'h1000_0000 + 32'(offs[i]), 32'h200 + 32'(4 * i)), 1,
            32'h80FF_7F01);
      else
        cyc(0, '0, 1, 32'h80FF_7F01);
      @(negedge clk);
      check($sformatf("subword_%0d", i - 1), 74'(mem_forward_data), 74'(exps[i - 1]));
    end

    // LW stalled for three cycles while SRAM data changes
    cyc(1, mk(0, 1, 1, 7, 32'h2000_0000, 32'h300), 1, 32'h0);
    cyc(0, '0, 0, 32'h1111_1111);
    @(negedge clk);
    check("stall_result_0", 74'(mem_forward_data), 74'(32'h1111_1111));
    check("stall_allowin_0", 74'(ifc.ms_allowin), 74'(0));
    for (int i = 1; i < 3; i++) begin
      cyc(0, '0, 0, 32'h2222_2222);
      @(negedge clk);
      check($sformatf("stall_result_%0d", i), 74'(mem_forward_data), 74'(32'h1111_1111));
      check($sformatf("stall_allowin_%0d", i), 74'(ifc.ms_allowin), 74'(0));
    end
    cyc(0, '0, 1, 32'h2222_2222);
    @(negedge clk);
    check("release_valid", 74'(ifc.ms_to_ws_valid), 74'(1));
    check("release_result", 74'(ifc.ms_to_ws_bus[63:32]), 74'(32'h1111_1111));
    cyc(0, '0, 1, 32'h2222_2222);
    @(negedge clk);
    check("release_once", 74'(ifc.ms_to_ws_valid), 74'(0));

    // Back-to-back ALU results, second one not writing
    cyc(1, mk(0, 0, 1, 3, 32'h0000_000A, 32'h400), 1, 32'hDEAD_BEEF);
    cyc(1, mk(0, 0, 0, 4, 32'h0000_000B, 32'h404), 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("alu_a", 74'(mem_forward_data), 74'(32'hA));
    check("alu_a_dest", 74'(ms_real_dest), 74'(3));
    cyc(0, '0, 1, 32'hDEAD_BEEF);
    @(negedge clk);
    check("alu_b_valid", 74'(ifc.ms_to_ws_valid), 74'(1));
    check("alu_b", 74'(mem_forward_data), 74'(32'hB));
    check("alu_b_nowrite_dest", 74'(ms_real_dest), 74'(0));

    // Reset during a stall drops the held instruction
    cyc(1, mk(0, 1, 1, 9, 32'h3000_0000, 32'h500), 1, 32'h0);
    cyc(0, '0, 0, 32'h3333_3333);
    @(negedge clk);
    check("pre_reset_valid", 74'(ifc.ms_to_ws_valid), 74'(1));
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    ifc.ws_allowin = 1'b1;
    @(negedge clk);
    check("midreset_valid", 74'(ifc.ms_to_ws_valid), 74'(0));
    check("midreset_dest", 74'(ms_real_dest), 74'(0));
    cyc(0, '0, 1, 32'h0);
    @(negedge clk);
    check("midreset_dropped", 74'(ifc.ms_to_ws_valid), 74'(0));

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset              = ($urandom_range(0, 199) == 0);
      ifc.es_to_ms_valid = $urandom_range(0, 3) != 0;
      ifc.es_to_ms_bus   = mk($urandom_range(0, 7), $urandom_range(0, 1) == 1,
                              $urandom_range(0, 1) == 1, $urandom_range(0, 31),
                              $urandom, $urandom);
      ifc.ws_allowin     = $urandom_range(0, 2) != 0;
      data_sram_rdata    = $urandom;
    end
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
